// File: rtl/mem_access_stage.sv
// Memory-stage data access: turns M-stage loads/stores into a req/ack bus
// transaction, steers store lanes, extends load data and stalls the pipe.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALU_outM,
    input  logic [31:0] WriteDataM,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_be,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        access_err,
    output logic        bus_timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] TLAST =
        (TIMEOUT_CYCLES == 0) ? 8'd0 : 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_nx;
    logic [31:0] cap;
    logic [7:0]  cnt;

    logic        acc;
    logic        is_st;
    logic        f3_ok;
    logic        misal;
    logic        legal;
    logic        to_hit;
    logic [1:0]  off;
    logic [3:0]  be_nx;
    logic [31:0] wd_nx;
    logic [31:0] sh;
    logic [7:0]  bsel;
    logic [15:0] hsel;

    assign off    = ALU_outM[1:0];
    assign acc    = MemReadM | MemWriteM;
    assign is_st  = MemWriteM;
    assign to_hit = (TIMEOUT_CYCLES != 0) && (cnt == TLAST);

    always_comb begin
        f3_ok = 1'b0;
        case (funct3M)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = ~is_st;
            default:                f3_ok = 1'b0;
        endcase
        misal = ((funct3M[1:0] == 2'b01) && off[0]) ||
                ((funct3M[1:0] == 2'b10) && (off != 2'b00));
        legal = acc & f3_ok & ~misal;
    end

    always_comb begin
        be_nx = 4'b1111;
        wd_nx = 32'd0;
        if (is_st) begin
            case (funct3M[1:0])
                2'b00: begin
                    be_nx = 4'b0001 << off;
                    wd_nx = {4{WriteDataM[7:0]}};
                end
                2'b01: begin
                    be_nx = 4'b0011 << off;
                    wd_nx = {2{WriteDataM[15:0]}};
                end
                default: begin
                    be_nx = 4'b1111;
                    wd_nx = WriteDataM;
                end
            endcase
        end
    end

    always_comb begin
        state_nx   = state;
        StallM     = 1'b0;
        access_err = 1'b0;
        unique case (state)
            IDLE: begin
                if (legal) begin
                    StallM   = 1'b1;
                    state_nx = BUS;
                end else if (acc) begin
                    access_err = 1'b1;
                end
            end
            BUS: begin
                StallM = 1'b1;
                if (dbus_ack || to_hit) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // Held in reset: nothing is stalled or flagged.
        if (!reset) begin
            StallM     = 1'b0;
            access_err = 1'b0;
        end
    end

    always_comb begin
        sh        = cap >> {off, 3'b000};
        bsel      = sh[7:0];
        hsel      = off[1] ? cap[31:16] : cap[15:0];
        ReadDataM = 32'd0;
        if (state == DONE && !MemWriteM) begin
            case (funct3M)
                3'b000:  ReadDataM = {{24{bsel[7]}}, bsel};
                3'b100:  ReadDataM = {24'd0, bsel};
                3'b001:  ReadDataM = {{16{hsel[15]}}, hsel};
                3'b101:  ReadDataM = {16'd0, hsel};
                3'b010:  ReadDataM = cap;
                default: ReadDataM = 32'd0;
            endcase
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            dbus_req    <= 1'b0;
            dbus_we     <= 1'b0;
            dbus_addr   <= 32'd0;
            dbus_wdata  <= 32'd0;
            dbus_be     <= 4'd0;
            cap         <= 32'd0;
            cnt         <= 8'd0;
            bus_timeout <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (legal) begin
                        dbus_req   <= 1'b1;
                        dbus_we    <= is_st;
                        dbus_addr  <= {ALU_outM[31:2], 2'b00};
                        dbus_wdata <= wd_nx;
                        dbus_be    <= be_nx;
                        cnt        <= 8'd0;
                    end
                end
                BUS: begin
                    if (dbus_ack) begin
                        dbus_req <= 1'b0;
                        cap      <= dbus_we ? 32'd0 : dbus_rdata;
                    end else if (to_hit) begin
                        dbus_req    <= 1'b0;
                        cap         <= 32'd0;
                        bus_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE:    bus_timeout <= 1'b0;
                default: bus_timeout <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: loads, stores, misalignment,
// bus timeout and asynchronous reset during a transaction.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALU_outM;
    logic [31:0] WriteDataM;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_be;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        access_err;
    logic        bus_timeout;

    int checks = 0;
    int errors = 0;
    int n;

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .funct3M    (funct3M),
        .ALU_outM   (ALU_outM),
        .WriteDataM (WriteDataM),
        .dbus_ack   (dbus_ack),
        .dbus_rdata (dbus_rdata),
        .dbus_req   (dbus_req),
        .dbus_we    (dbus_we),
        .dbus_addr  (dbus_addr),
        .dbus_wdata (dbus_wdata),
        .dbus_be    (dbus_be),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .access_err (access_err),
        .bus_timeout(bus_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        funct3M    = 3'b000;
        ALU_outM   = 32'd0;
        WriteDataM = 32'd0;
        dbus_ack   = 1'b0;
        dbus_rdata = 32'd0;
    endtask

    // One full transaction with ack during the first BUS cycle.
    task automatic txn(input string tag, input logic rd, input logic wr,
                       input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdat, input logic [31:0] rdat,
                       input logic [3:0] ebe, input logic [31:0] ewd,
                       input logic [31:0] erd);
        MemReadM   = rd;
        MemWriteM  = wr;
        funct3M    = f3;
        ALU_outM   = addr;
        WriteDataM = wdat;
        #1;
        check({tag, "_idle_stall"}, 32'(StallM), 32'd1);
        step();
        check({tag, "_req"}, 32'(dbus_req), 32'd1);
        check({tag, "_we"}, 32'(dbus_we), 32'(wr));
        check({tag, "_addr"}, dbus_addr, {addr[31:2], 2'b00});
        check({tag, "_be"}, 32'(dbus_be), 32'(ebe));
        check({tag, "_wdata"}, dbus_wdata, ewd);
        check({tag, "_bus_stall"}, 32'(StallM), 32'd1);
        check({tag, "_bus_rd0"}, ReadDataM, 32'd0);
        dbus_ack   = 1'b1;
        dbus_rdata = rdat;
        step();
        dbus_ack   = 1'b0;
        dbus_rdata = 32'd0;
        check({tag, "_done_stall"}, 32'(StallM), 32'd0);
        check({tag, "_done_req"}, 32'(dbus_req), 32'd0);
        check({tag, "_rdata"}, ReadDataM, erd);
        step();
        idle_inputs();
        #1;
        check({tag, "_back_idle"}, 32'(StallM), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        step();
        check("rst_req", 32'(dbus_req), 32'd0);
        step();
        reset = 1'b1;
        #1;
        check("rst_we", 32'(dbus_we), 32'd0);
        check("rst_addr", dbus_addr, 32'd0);
        check("rst_wdata", dbus_wdata, 32'd0);
        check("rst_be", 32'(dbus_be), 32'd0);
        check("rst_stall", 32'(StallM), 32'd0);
        check("rst_rdm", ReadDataM, 32'd0);
        check("rst_err", 32'(access_err), 32'd0);
        check("rst_to", 32'(bus_timeout), 32'd0);
        step();

        txn("lw", 1, 0, 3'b010, 32'h1004, 32'd0, 32'hDEADBEEF,
            4'b1111, 32'd0, 32'hDEADBEEF);

        txn("lb1", 1, 0, 3'b000, 32'h1001, 32'd0, 32'h80FF7F01,
            4'b1111, 32'd0, 32'h0000007F);
        txn("lb2", 1, 0, 3'b000, 32'h1002, 32'd0, 32'h80FF7F01,
            4'b1111, 32'd0, 32'hFFFFFFFF);
        txn("lbu3", 1, 0, 3'b100, 32'h1003, 32'd0, 32'h80FF7F01,
            4'b1111, 32'd0, 32'h00000080);
        txn("lh2", 1, 0, 3'b001, 32'h1002, 32'd0, 32'h80FF7F01,
            4'b1111, 32'd0, 32'hFFFF80FF);
        txn("lhu2", 1, 0, 3'b101, 32'h1002, 32'd0, 32'h80FF7F01,
            4'b1111, 32'd0, 32'h000080FF);

        txn("sb", 0, 1, 3'b000, 32'h2003, 32'h000000AB, 32'h55555555,
            4'b1000, 32'hABABABAB, 32'd0);
        txn("sh", 0, 1, 3'b001, 32'h2002, 32'h00001234, 32'h55555555,
            4'b1100, 32'h12341234, 32'd0);
        txn("sw_rdwr", 1, 1, 3'b010, 32'h2008, 32'hCAFEF00D, 32'h55555555,
            4'b1111, 32'hCAFEF00D, 32'd0);

        MemReadM = 1'b1;
        funct3M  = 3'b010;
        ALU_outM = 32'h3002;
        #1;
        check("mis_lw_err", 32'(access_err), 32'd1);
        check("mis_lw_stall", 32'(StallM), 32'd0);
        check("mis_lw_rdm", ReadDataM, 32'd0);
        step();
        check("mis_lw_req", 32'(dbus_req), 32'd0);
        idle_inputs();
        MemWriteM  = 1'b1;
        funct3M    = 3'b001;
        ALU_outM   = 32'h3001;
        WriteDataM = 32'h00001234;
        #1;
        check("mis_sh_err", 32'(access_err), 32'd1);
        check("mis_sh_stall", 32'(StallM), 32'd0);
        check("mis_sh_rdm", ReadDataM, 32'd0);
        step();
        check("mis_sh_req", 32'(dbus_req), 32'd0);
        idle_inputs();
        funct3M  = 3'b100;
        MemWriteM = 1'b1;
        #1;
        check("bad_f3_err", 32'(access_err), 32'd1);
        idle_inputs();
        step();

        MemReadM = 1'b1;
        funct3M  = 3'b010;
        ALU_outM = 32'h4000;
        step();
        n = 0;
        while (dbus_req === 1'b1 && n < 20) begin
            n++;
            step();
        end
        check("to_req_cycles", 32'(n), 32'd4);
        check("to_pulse", 32'(bus_timeout), 32'd1);
        check("to_rdm", ReadDataM, 32'd0);
        check("to_stall", 32'(StallM), 32'd0);
        step();
        check("to_pulse_clr", 32'(bus_timeout), 32'd0);
        check("to_idle_restall", 32'(StallM), 32'd1);
        check("to_idle_req", 32'(dbus_req), 32'd0);
        idle_inputs();
        step();

        MemReadM = 1'b1;
        funct3M  = 3'b010;
        ALU_outM = 32'h5008;
        step();
        check("mr_bus_req", 32'(dbus_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("mr_req", 32'(dbus_req), 32'd0);
        check("mr_stall", 32'(StallM), 32'd0);
        idle_inputs();
        step();
        reset = 1'b1;
        dbus_ack   = 1'b1;
        dbus_rdata = 32'h12345678;
        step();
        check("mr_late_req", 32'(dbus_req), 32'd0);
        check("mr_late_stall", 32'(StallM), 32'd0);
        check("mr_late_rdm", ReadDataM, 32'd0);
        idle_inputs();
        step();
        txn("mr_lw", 1, 0, 3'b010, 32'h500C, 32'd0, 32'h0BADF00D,
            4'b1111, 32'd0, 32'h0BADF00D);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-stage data-access unit that sits between the E-to-M pipeline register and the M-to-W pipeline register.
- Converts MemReadM/MemWriteM and funct3M into a word-aligned req/ack data-bus transaction, with byte enables and byte-lane steering for stores.
- Sign- or zero-extends load data to produce ReadDataM for the writeback register.
- Holds the pipeline through StallM while a transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16: BUS-state cycles without dbus_ack before the access is aborted; 0 disables the timeout; range 0..255.

Ports:
- clk  in  1  clock; all state updates on the falling edge, matching the pipeline registers
- reset  in  1  asynchronous active-low reset
- MemReadM  in  1  load in M stage
- MemWriteM  in  1  store in M stage
- funct3M  in  3  access size/sign (RV32I load/store encoding)
- ALU_outM  in  32  effective byte address
- WriteDataM  in  32  store data (rs2)
- dbus_ack  in  1  bus completion, sampled on falling edge
- dbus_rdata  in  32  bus read word, valid with dbus_ack
- dbus_req  out  1  registered request
- dbus_we  out  1  registered write enable
- dbus_addr  out  32  registered word address, {ALU_outM[31:2],2'b00}
- dbus_wdata  out  32  registered lane-steered store data
- dbus_be  out  4  registered byte enables
- ReadDataM  out  32  extended load data to the M-to-W register
- StallM  out  1  freeze PC, F/D/E/M registers
- access_err  out  1  misaligned or unsupported access (no bus cycle)
- bus_timeout  out  1  one-cycle pulse, access aborted

Behaviour:
- FSM states are IDLE, BUS and DONE. Reset (asynchronous, any state) forces:
  - state IDLE, dbus_req=0, dbus_we=0, dbus_addr=0, dbus_wdata=0, dbus_be=0;
  - capture register=0, timeout counter=0, bus_timeout=0.
- Combinational outputs after reset: StallM=0, ReadDataM=0, access_err=0.
- Access decode:
  - acc = MemReadM|MemWriteM.
  - If both MemReadM and MemWriteM are set, the access is a store.
  - Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal store funct3: 000 SB, 001 SH, 010 SW.
  - Any other funct3 is an error.
  - Halfword accesses with addr[0]=1 are misaligned; word accesses with addr[1:0]!=0 are misaligned.
- IDLE:
  - Legal acc: StallM=1 combinationally. At the next falling edge go to BUS and load the dbus_* registers, with dbus_req=1 and counter=0.
  - Illegal acc: access_err=1 combinationally, StallM=0, no bus cycle, ReadDataM=0, no state change.
  - dbus_ack in IDLE is ignored.
- Store lane steering, with off=addr[1:0]:
  - SB: be=4'b0001<<off; wdata = byte replicated 4x.
  - SH: be=4'b0011<<off; wdata = halfword replicated 2x.
  - SW: be=4'b1111; wdata = WriteDataM.
- Loads drive dbus_be=4'b1111 and dbus_wdata=0.
- BUS:
  - StallM=1.
  - dbus_ack=1 at a falling edge: capture dbus_rdata (loads only), drop dbus_req, go to DONE.
  - Otherwise increment the counter.
  - When TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 without ack: drop dbus_req, capture 0, set bus_timeout=1, go to DONE.
- DONE:
  - StallM=0. The pipeline advances at this falling edge.
  - ReadDataM = extract(capture, off, funct3M).
  - LB/LBU select byte off; LH/LHU select halfword off[1]. Sign-extend for LB/LH, zero-extend otherwise. Stores give ReadDataM=0.
  - No new access is started in DONE. The next edge goes unconditionally to IDLE and clears bus_timeout.
- ReadDataM=0 in IDLE and BUS.
- Minimum latency with same-cycle ack: 2 stalled cycles plus the DONE cycle.
- Back-to-back accesses: the second access is evaluated in the IDLE cycle after DONE.

Test Plan:
- Aligned load, ack one cycle after req:
  - Stimulus: LW at 0x1004, dbus_rdata=0xDEADBEEF.
  - Required: dbus_addr=0x1004, be=1111, StallM high for exactly 2 cycles, ReadDataM=0xDEADBEEF in DONE.
- Byte and halfword load extraction with capture word 0x80FF7F01:
  - LB off=1 -> 0x0000007F; LB off=2 -> 0xFFFFFFFF; LBU off=3 -> 0x00000080; LH off=2 -> 0xFFFF80FF; LHU off=2 -> 0x000080FF.
- Store lane steering:
  - SB addr 0x2003, data 0x000000AB -> be=1000, wdata=0xABABABAB, dbus_we=1.
  - SH addr 0x2002, data 0x1234 -> be=1100, wdata=0x12341234.
- Misaligned access:
  - LW addr 0x3002 -> access_err=1, StallM=0, dbus_req stays 0, ReadDataM=0.
  - SH addr 0x3001 -> same response.
- Timeout: TIMEOUT_CYCLES=4, load with ack never asserted -> dbus_req high for 4 cycles, then DONE with bus_timeout=1 for 1 cycle, ReadDataM=0, IDLE on the next edge.
- Reset mid-operation: reset low while in BUS -> dbus_req=0 and StallM=0 immediately (asynchronous); a late dbus_ack after reset release is ignored; a fresh LW then completes normally.
